lsu_mem_req: RTL and testbench
==============================

Name: lsu_mem_req

Overview:
- Load/store initiator that sits between the EXU/LSU stage and the data-memory responder.
- Accepts one load or store per handshake and converts it into a word-aligned memory request: valid, read/write address, 8-bit byte mask, shifted write data.
- Waits for the responder's completion, then returns load data (aligned, sign/zero-extended) or a store acknowledgement to the core.
- Detects misaligned accesses and reports them without issuing a memory request.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 255, number of cycles in WAIT without mem_rvalid before an error response is returned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or timeout
- mem_valid  out  1  memory request valid
- mem_ready  in  1  responder accepts request
- mem_raddr  out  XLEN  word-aligned read address
- mem_wen  out  1  write request
- mem_waddr  out  XLEN  word-aligned write address
- mem_wmask  out  8  byte mask; bits [7:4] always 0
- mem_wdata  out  XLEN  write data shifted into the addressed byte lanes
- mem_rvalid  in  1  responder completion; mem_rdata valid this cycle
- mem_rdata  in  XLEN  full read word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, except req_ready=1.
  - Any in-flight transaction is dropped; no response is produced for it.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register wen, funct3, addr and wdata.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0), or undefined funct3: go to RESP with resp_err=1; no mem_valid is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1; all mem_* outputs are stable, driven from registers.
  - raddr = waddr = {addr[XLEN-1:2],2'b00}.
  - mem_wen = registered wen.
  - On mem_ready, go to WAIT.
  - mem_valid may be asserted for multiple cycles; it is never dropped before mem_ready.
- WAIT:
  - mem_valid=0.
  - On mem_rvalid, capture mem_rdata, go to RESP, and clear the timeout counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with resp_err=1.
  - mem_rvalid in the same cycle as mem_ready (zero-latency responder) is legal and is captured directly from REQ.
- RESP:
  - resp_valid=1; outputs are held until resp_ready.
  - On resp_ready, go to IDLE.
  - req_ready=0 outside IDLE, so there is no back-to-back overlap.
  - Minimum latency, req handshake to resp_valid: 2 cycles with a zero-latency responder.
- Store mask: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
- Store data: wdata << (8*a[1:0]), with lanes replicated.
- Load extract: word >> (8*a[1:0]); then sign- or zero-extend from bit 7 or 15 per funct3.
- Loads drive mem_wmask=0. Stores ignore the mem_rdata value but still wait for mem_rvalid as the write acknowledgement.
- req_valid while busy is ignored (req_ready=0); the requester holds it.

Decomposition:
- Shared package lsu_pkg:
  - FSM state enum.
  - funct3 size/sign constants.
  - Misalign-check function.
- Sub-module lsu_align (combinational): mask/wdata shifting and load extraction/extension. It is reused by any future cache-side path.

Test Plan:
- Store byte: req_wen=1, f3=000, addr=0x8000_0003, wdata=0xAB, mem_ready=1 → mem_wmask=0x08, mem_wdata[31:24]=0xAB, mem_waddr=0x8000_0000; resp_valid two cycles after the request, resp_err=0.
- Load sign-extend: f3=001, addr=0x8000_0002, mem_rdata=0x8123_4567 → resp_rdata=0xFFFF_8123; the same case with f3=101 → 0x0000_8123.
- Misaligned: lw at 0x8000_0001 → mem_valid never asserted; resp_valid next cycle with resp_err=1, resp_rdata=0.
- Backpressure: mem_ready low for 3 cycles, mem_rvalid 2 cycles later, resp_ready low for 2 cycles → mem_* stable throughout REQ, resp_* held stable, req_ready=0 until the resp handshake.
- Timeout/reset: TIMEOUT=4 with mem_rvalid never asserted → resp_err=1 after 4 WAIT cycles. Separately, rst_n=0 during WAIT → next cycle IDLE, req_ready=1, no resp_valid, and a following lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory-request path: FSM states,
// RV32 funct3 size/sign encodings and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the access must be rejected: misaligned, or funct3 undefined
    // for this direction (stores have no unsigned forms).
    function automatic logic access_bad(input logic       wen,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = offset[0];
            F3_W:    bad = (offset != 2'b00);
            F3_BU:   bad = wen;
            F3_HU:   bad = wen | offset[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_req_if.sv
// Core-side request/response and memory-side request/completion signals of
// the load/store initiator; master is the initiator, slave is its environment.
interface lsu_mem_req_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_raddr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_waddr;
    logic [7:0]      mem_wmask;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
    );

    modport slave (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wmask, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement and load extraction with
// sign/zero extension. Purely combinational so other memory paths can reuse it.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic            wen_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      wmask_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] rshift;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        wmask_o = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = '0;
        rshift  = rdata_i >> {offset_i, 3'b000};

        // Replicating the low lanes places the data at every possible offset;
        // the mask selects which lanes are actually written.
        case (funct3_i[1:0])
            2'b00: begin
                wmask_o = 4'b0001 << offset_i;
                wdata_o = {(XLEN/8){wdata_i[7:0]}};
            end
            2'b01: begin
                wmask_o = 4'b0011 << offset_i;
                wdata_o = {(XLEN/16){wdata_i[15:0]}};
            end
            default: wmask_o = 4'b1111;
        endcase
        if (!wen_i) wmask_o = 4'b0000;

        case (funct3_i)
            F3_B:    rdata_o = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            F3_H:    rdata_o = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            F3_BU:   rdata_o = {{(XLEN-8){1'b0}}, rshift[7:0]};
            F3_HU:   rdata_o = {{(XLEN-16){1'b0}}, rshift[15:0]};
            default: rdata_o = rshift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_req.sv
// Load/store initiator: turns one core load/store into a word-aligned memory
// request, waits for completion (or timeout) and returns the response.
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    lsu_mem_req_if.master bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e      state_q, state_d;
    logic            wen_q, wen_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]      lane_mask;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] word_addr;
    logic            timeout_hit;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i (f3_q),
        .offset_i (addr_q[1:0]),
        .wen_i    (wen_q),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.mem_rdata),
        .wmask_o  (lane_mask),
        .wdata_o  (lane_wdata),
        .rdata_o  (load_data)
    );

    assign word_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign load_word   = wen_q ? '0 : load_data;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_raddr  = '0;
        bus.mem_waddr  = '0;
        bus.mem_wmask  = 8'h00;
        bus.mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = access_bad(bus.req_wen, bus.req_funct3, bus.req_addr[1:0]);
                    state_d = err_d ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                bus.mem_valid = 1'b1;
                bus.mem_wen   = wen_q;
                bus.mem_raddr = word_addr;
                bus.mem_waddr = word_addr;
                bus.mem_wmask = {4'b0000, lane_mask};
                bus.mem_wdata = wen_q ? lane_wdata : '0;
                if (bus.mem_ready) begin
                    // A zero-latency responder completes in the accept cycle.
                    if (bus.mem_rvalid) begin
                        rdata_d = load_word;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d = load_word;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
        if (!rst_n) begin
            state_q <= S_IDLE;
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req: stores, loads, misalignment, backpressure,
// timeout and mid-transaction reset, with responses checked against a scoreboard.
module tb_lsu_mem_req;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic  clk;
    logic  rst_n;
    int    checks = 0;
    int    errors = 0;
    resp_t sb_q[$];

    lsu_mem_req_if #(.XLEN(32)) bus ();

    lsu_mem_req #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour written from the RV32 load/store rules.
    function automatic resp_t model(input logic wen, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] word);
        resp_t       r;
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        r.err   = 1'b0;
        r.rdata = 32'h0;
        sh      = 8 * int'(addr[1:0]);
        b       = 8'(word >> sh);
        h       = 16'(word >> sh);
        case (f3)
            3'b000: r.rdata = {{24{b[7]}}, b};
            3'b100: begin r.err = wen; r.rdata = {24'h0, b}; end
            3'b001: begin r.err = addr[0]; r.rdata = {{16{h[15]}}, h}; end
            3'b101: begin r.err = wen | addr[0]; r.rdata = {16'h0, h}; end
            3'b010: begin r.err = (addr[1:0] != 2'b00); r.rdata = word; end
            default: r.err = 1'b1;
        endcase
        if (wen || r.err) r.rdata = 32'h0;
        return r;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge; the DUT must be idle.
    task automatic drive_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] word, input bit push);
        check_bit("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_wen    = wen;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        if (push) sb_q.push_back(model(wen, f3, addr, word));
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        resp_t e;
        int    n = 0;
        while (bus.resp_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_bit("resp_valid_seen", bus.resp_valid, 1'b1);
        if (bus.resp_valid === 1'b1) begin
            check32("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check32("resp_rdata", bus.resp_rdata, e.rdata);
                check_bit("resp_err", bus.resp_err, e.err);
            end
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
            check_bit("resp_drop", bus.resp_valid, 1'b0);
            check_bit("req_ready_back", bus.req_ready, 1'b1);
        end
    endtask

    // Load against a zero-latency responder; exp is the hand-derived result.
    task automatic load_zl(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
        drive_req(1'b0, f3, addr, 32'h0, word, 1'b1);
        check_bit("ld_mem_valid", bus.mem_valid, 1'b1);
        check_bit("ld_mem_wen", bus.mem_wen, 1'b0);
        check32("ld_wmask", 32'(bus.mem_wmask), 32'h0);
        check32("ld_raddr", bus.mem_raddr, {addr[31:2], 2'b00});
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = word;
        tick();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        check_bit("ld_lat2", bus.resp_valid, 1'b1);
        check32("ld_const", bus.resp_rdata, exp);
        wait_resp(2);
    endtask

    task automatic store_zl(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] exp_mask, input logic [31:0] exp_lanes);
        drive_req(1'b1, f3, addr, wdata, 32'hDEAD_BEEF, 1'b1);
        check_bit("st_mem_valid", bus.mem_valid, 1'b1);
        check_bit("st_mem_wen", bus.mem_wen, 1'b1);
        check32("st_wmask", 32'(bus.mem_wmask), 32'(exp_mask));
        check32("st_lanes", bus.mem_wdata & {{8{exp_mask[3]}}, {8{exp_mask[2]}},
                                             {8{exp_mask[1]}}, {8{exp_mask[0]}}}, exp_lanes);
        check32("st_waddr", bus.mem_waddr, {addr[31:2], 2'b00});
        check_bit("st_busy", bus.req_ready, 1'b0);
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        check_bit("st_lat2", bus.resp_valid, 1'b1);
        check_bit("st_mem_idle", bus.mem_valid, 1'b0);
        wait_resp(2);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset state
        tick();
        tick();
        check_bit("rst_req_ready", bus.req_ready, 1'b1);
        check_bit("rst_resp_valid", bus.resp_valid, 1'b0);
        check_bit("rst_resp_err", bus.resp_err, 1'b0);
        check32("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_bit("rst_mem_valid", bus.mem_valid, 1'b0);
        check_bit("rst_mem_wen", bus.mem_wen, 1'b0);
        check32("rst_wmask", 32'(bus.mem_wmask), 32'h0);
        rst_n = 1'b1;
        tick();

        // Stores: byte at lane 3, half at lane 2, full word
        store_zl(3'b000, 32'h8000_0003, 32'h0000_00AB, 8'h08, 32'hAB00_0000);
        store_zl(3'b001, 32'h8000_0002, 32'h1234_CDEF, 8'h0C, 32'hCDEF_0000);
        store_zl(3'b010, 32'h8000_0004, 32'hA5A5_5A5A, 8'h0F, 32'hA5A5_5A5A);

        // Loads with sign/zero extension
        load_zl(3'b001, 32'h8000_0002, 32'h8123_4567, 32'hFFFF_8123);
        load_zl(3'b101, 32'h8000_0002, 32'h8123_4567, 32'h0000_8123);
        load_zl(3'b000, 32'h8000_0001, 32'h1234_8056, 32'hFFFF_FF80);
        load_zl(3'b100, 32'h8000_0003, 32'hF000_0000, 32'h0000_00F0);
        load_zl(3'b010, 32'h8000_0008, 32'h89AB_CDEF, 32'h89AB_CDEF);

        // Misaligned / undefined accesses: immediate error, no memory request
        drive_req(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1'b1);
        check_bit("mis_lw_no_mem", bus.mem_valid, 1'b0);
        check_bit("mis_lw_resp", bus.resp_valid, 1'b1);
        check_bit("mis_lw_err", bus.resp_err, 1'b1);
        check32("mis_lw_rdata", bus.resp_rdata, 32'h0);
        wait_resp(1);
        check_bit("mis_lw_still_no_mem", bus.mem_valid, 1'b0);
        drive_req(1'b1, 3'b001, 32'h8000_0001, 32'h1234, 32'h0, 1'b1);
        check_bit("mis_sh_no_mem", bus.mem_valid, 1'b0);
        wait_resp(1);
        drive_req(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
        check_bit("bad_f3_no_mem", bus.mem_valid, 1'b0);
        wait_resp(1);

        // Backpressure on both sides, plus a request presented while busy
        drive_req(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h1122_3344, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_bit("bp_mem_valid", bus.mem_valid, 1'b1);
            check32("bp_raddr", bus.mem_raddr, 32'h8000_0010);
            check32("bp_waddr", bus.mem_waddr, 32'h8000_0010);
            check_bit("bp_mem_wen", bus.mem_wen, 1'b0);
            check32("bp_wmask", 32'(bus.mem_wmask), 32'h0);
            check_bit("bp_req_ready", bus.req_ready, 1'b0);
            tick();
        end
        check_bit("bp_mem_valid_held", bus.mem_valid, 1'b1);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_wen    = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0100;
        bus.req_wdata  = 32'hFFFF_FFFF;
        check_bit("bp_wait_mem_idle", bus.mem_valid, 1'b0);
        check_bit("bp_wait_busy", bus.req_ready, 1'b0);
        tick();
        check_bit("bp_wait2_no_resp", bus.resp_valid, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check_bit("bp_resp_held", bus.resp_valid, 1'b1);
            check32("bp_resp_rdata", bus.resp_rdata, 32'h1122_3344);
            check_bit("bp_resp_err", bus.resp_err, 1'b0);
            check_bit("bp_resp_busy", bus.req_ready, 1'b0);
            tick();
        end
        bus.req_valid = 1'b0;
        wait_resp(1);
        tick();
        check_bit("bp_busy_req_dropped", bus.mem_valid, 1'b0);

        // Timeout after four WAIT cycles without completion
        sb_q.push_back(resp_t'{err: 1'b1, rdata: 32'h0});
        drive_req(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 1'b0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_bit("to_wait_no_resp", bus.resp_valid, 1'b0);
            check_bit("to_wait_mem_idle", bus.mem_valid, 1'b0);
            tick();
        end
        check_bit("to_resp", bus.resp_valid, 1'b1);
        check_bit("to_err", bus.resp_err, 1'b1);
        wait_resp(1);

        // Reset while waiting drops the transaction; the next load works
        drive_req(1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 1'b0);
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_bit("mid_rst_req_ready", bus.req_ready, 1'b1);
        check_bit("mid_rst_no_resp", bus.resp_valid, 1'b0);
        check_bit("mid_rst_mem_idle", bus.mem_valid, 1'b0);
        tick();
        check_bit("mid_rst_still_no_resp", bus.resp_valid, 1'b0);
        load_zl(3'b010, 32'h8000_0044, 32'hCAFE_F00D, 32'hCAFE_F00D);

        check32("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
